// File: rtl/aes_round_scheduler.sv
// Sequencer for an iterative one-round-per-cycle AES datapath: key load, block load, rounds 0..NR, ciphertext out.
// Latency: block accepted at T -> LOAD at T+1, ROUND T+2..T+NR+1, out_valid at T+NR+2; minimum block period NR+3.
// Backpressure: out_valid holds with stable out_data until out_ready; no key or block is accepted outside IDLE.
module aes_round_scheduler #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         kx_start,
    input  logic         kx_done,
    output logic         key_loaded,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [127:0] dp_data,
    output logic         dp_load,
    output logic         dp_en,
    output logic         dp_final,
    output logic [3:0]   rk_sel,
    input  logic [127:0] dp_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // Only the three AES key sizes are meaningful round counts.
    generate
        if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
            $error("aes_round_scheduler: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] LP_NR = 4'(NR);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_LOAD   = 3'd2,
        S_ROUND  = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic           r_key_loaded;
    logic           r_kx_first;     // first cycle spent in KEYEXP
    logic [127:0]   r_dp_data;
    logic [3:0]     r_cnt;          // round counter, 1..NR while in ROUND
    logic           r_out_first;    // first cycle spent in OUT
    logic [127:0]   r_out_data;

    logic           w_key_ready;
    logic           w_in_ready;
    logic           w_key_hs;
    logic           w_in_hs;
    logic           w_last_round;

    // Request acceptance: combinational from state, key_loaded and key_valid only; a key beats a block.
    assign w_key_ready  = (r_state == S_IDLE);
    assign w_in_ready   = (r_state == S_IDLE) && r_key_loaded && !key_valid;
    assign w_key_hs     = key_valid && w_key_ready;
    assign w_in_hs      = in_valid && w_in_ready;
    assign w_last_round = (r_state == S_ROUND) && (r_cnt == LP_NR);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_key_hs) begin
                    w_next = S_KEYEXP;
                end else if (w_in_hs) begin
                    w_next = S_LOAD;
                end
            end
            S_KEYEXP: begin
                if (kx_done) begin
                    w_next = S_IDLE;
                end
            end
            S_LOAD: begin
                w_next = S_ROUND;
            end
            S_ROUND: begin
                if (w_last_round) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Key schedule validity and the key-expansion start marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_loaded <= 1'b0;
            r_kx_first   <= 1'b0;
        end else begin
            r_kx_first <= w_key_hs;
            if (w_key_hs) begin
                r_key_loaded <= 1'b0;
            end else if ((r_state == S_KEYEXP) && kx_done) begin
                r_key_loaded <= 1'b1;
            end
        end
    end

    // Block register and round counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_data <= '0;
            r_cnt     <= 4'd0;
        end else begin
            if (w_in_hs) begin
                r_dp_data <= in_data;
            end
            if (r_state == S_LOAD) begin
                r_cnt <= 4'd1;
            end else if ((r_state == S_ROUND) && !w_last_round) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Ciphertext capture. The datapath register only holds the final-round
    // result from the first OUT cycle on, so it is captured at the end of
    // that cycle; any reset drops a pending ciphertext.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_first <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_first <= w_last_round;
            if (r_out_first) begin
                r_out_data <= dp_state;
            end
        end
    end

    // Output decode: every datapath control is zero outside its own state.
    always_comb begin
        key_ready  = w_key_ready;
        in_ready   = w_in_ready;
        key_loaded = r_key_loaded;
        dp_data    = r_dp_data;
        kx_start   = 1'b0;
        dp_load    = 1'b0;
        dp_en      = 1'b0;
        dp_final   = 1'b0;
        rk_sel     = 4'd0;
        out_valid  = 1'b0;
        busy       = (r_state != S_IDLE);
        // First OUT cycle forwards the datapath register while it is being captured.
        out_data   = r_out_first ? dp_state : r_out_data;
        case (r_state)
            S_KEYEXP: begin
                kx_start = r_kx_first;
            end
            S_LOAD: begin
                dp_load = 1'b1;
            end
            S_ROUND: begin
                dp_en    = 1'b1;
                rk_sel   = r_cnt;
                dp_final = (r_cnt == LP_NR);
            end
            S_OUT: begin
                out_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_scheduler.sv
module tb_aes_round_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid, key_ready, kx_start, kx_done, key_loaded;
    logic         in_valid, in_ready;
    logic [127:0] in_data, dp_data, dp_state, out_data;
    logic         dp_load, dp_en, dp_final;
    logic [3:0]   rk_sel;
    logic         out_valid, out_ready, busy;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    aes_round_scheduler #(.NR(10)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_ready(key_ready), .kx_start(kx_start),
        .kx_done(kx_done), .key_loaded(key_loaded),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_data(dp_data), .dp_load(dp_load), .dp_en(dp_en), .dp_final(dp_final),
        .rk_sel(rk_sel), .dp_state(dp_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    // ---------------- FIPS-197 reference datapath and key schedule ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                               input logic fin);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) t[rw+4*c] = s[rw+4*((c+rw)%4)];
        for (int c = 0; c < 4; c++) begin
            if (fin) begin
                for (int rw = 0; rw < 4; rw++) s[rw+4*c] = t[rw+4*c];
            end else begin
                s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r ^ k;
    endfunction

    logic [127:0] rk [0:10];
    logic [127:0] m_state;

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])}
                      ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Datapath stand-in: registered state, loads with round key 0, one round per dp_en.
    always @(posedge clk) begin
        if (dp_load === 1'b1)     m_state <= dp_data ^ rk[0];
        else if (dp_en === 1'b1)  m_state <= aes_round(m_state, rk[rk_sel], dp_final);
    end
    assign dp_state = m_state;

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [8:0] v;
        rst = 1'b1; key_valid = 0; kx_done = 0; in_valid = 0; in_data = '0; out_ready = 0;
        repeat (3) tick;
        rst = 1'b0;
        v = {key_ready, in_ready, kx_start, key_loaded, dp_load, dp_en, dp_final, out_valid, busy};
        n_checks++; if (v !== 9'b1_0000_0000) $display("FAIL reset_ctrl: got %b want %b", v, 9'b1_0000_0000); else n_pass++;
        n_checks++; if (rk_sel !== 4'd0) $display("FAIL reset_rk_sel: got %0d want 0", rk_sel); else n_pass++;
        n_checks++; if (dp_data !== '0 || out_data !== '0) $display("FAIL reset_data: dp_data %h out_data %h want 0", dp_data, out_data); else n_pass++;
        tick;
        n_checks++; if (key_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_idle: key_ready %b busy %b want 1 0", key_ready, busy); else n_pass++;
    endtask

    task automatic test_no_key_stall;
        int bad = 0;
        in_valid = 1'b1; in_data = PT;
        for (int c = 0; c < 50; c++) begin
            kx_done = (c >= 10 && c < 13);
            if (in_ready !== 1'b0 || dp_load !== 1'b0) bad++;
            tick;
        end
        in_valid = 1'b0; kx_done = 1'b0;
        n_checks++; if (bad != 0) $display("FAIL no_key_stall: %0d cycles with in_ready/dp_load high, want 0", bad); else n_pass++;
        n_checks++; if (key_loaded !== 1'b0 || busy !== 1'b0) $display("FAIL stray_kx_done: key_loaded %b busy %b want 0 0", key_loaded, busy); else n_pass++;
    endtask

    task automatic test_key_load;
        int pulses = 0;
        key_valid = 1'b1;
        #1;
        n_checks++; if (key_ready !== 1'b1) $display("FAIL key_ready_idle: got %b want 1", key_ready); else n_pass++;
        tick;                                   // T+1
        key_valid = 1'b0;
        pulses += int'(kx_start);
        n_checks++; if (kx_start !== 1'b1 || busy !== 1'b1) $display("FAIL kx_start_t1: kx_start %b busy %b want 1 1", kx_start, busy); else n_pass++;
        tick; pulses += int'(kx_start);         // T+2
        tick; pulses += int'(kx_start);         // T+3
        tick; pulses += int'(kx_start);         // T+4 = K
        kx_done = 1'b1;
        n_checks++; if (busy !== 1'b1 || key_loaded !== 1'b0) $display("FAIL keyexp_hold: busy %b key_loaded %b want 1 0", busy, key_loaded); else n_pass++;
        tick;                                   // K+1
        kx_done = 1'b0;
        pulses += int'(kx_start);
        n_checks++; if (key_loaded !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL key_loaded_k1: key_loaded %b busy %b in_ready %b want 1 0 1", key_loaded, busy, in_ready); else n_pass++;
        n_checks++; if (pulses != 1) $display("FAIL kx_start_pulses: got %0d want 1", pulses); else n_pass++;
    endtask

    task automatic test_encrypt;
        logic [7:0] got, exp;
        in_data = PT; in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL in_ready_loaded: got %b want 1", in_ready); else n_pass++;
        tick;                                   // T+1 LOAD
        in_valid = 1'b0; in_data = '0;
        n_checks++; if ({dp_load, dp_en, rk_sel} !== 6'b10_0000 || dp_data !== PT) $display("FAIL load_cycle: dp_load %b dp_en %b rk_sel %0d dp_data %h want 1 0 0 %h", dp_load, dp_en, rk_sel, dp_data, PT); else n_pass++;
        for (int i = 1; i <= 10; i++) begin
            tick;                               // T+1+i ROUND
            got = {dp_en, dp_load, dp_final, rk_sel, out_valid};
            exp = {1'b1, 1'b0, (i == 10), 4'(i), 1'b0};
            n_checks++; if (got !== exp) $display("FAIL round_%0d: {en,load,final,rk_sel,out_valid} got %b want %b", i, got, exp); else n_pass++;
        end
        tick;                                   // T+12 OUT
        n_checks++; if (out_valid !== 1'b1 || dp_en !== 1'b0 || busy !== 1'b1) $display("FAIL out_valid_t12: out_valid %b dp_en %b busy %b want 1 0 1", out_valid, dp_en, busy); else n_pass++;
        n_checks++; if (out_data !== CT) $display("FAIL ciphertext: got %h want %h", out_data, CT); else n_pass++;
    endtask

    task automatic test_out_stall;
        logic [130:0] got;
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick;
            got = {out_valid, in_ready, busy, out_data};
            n_checks++; if (got !== {3'b101, CT}) $display("FAIL stall_%0d: valid %b in_ready %b busy %b data %h want 1 0 1 %h", c, out_valid, in_ready, busy, out_data, CT); else n_pass++;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL out_release: out_valid %b in_ready %b busy %b want 0 1 0", out_valid, in_ready, busy); else n_pass++;
    endtask

    task automatic test_key_priority;
        key_valid = 1'b1; in_valid = 1'b1; in_data = PT;
        #1;
        n_checks++; if (in_ready !== 1'b0 || key_ready !== 1'b1) $display("FAIL key_wins_ready: in_ready %b key_ready %b want 0 1", in_ready, key_ready); else n_pass++;
        tick;                                   // KEYEXP, kx_start cycle
        key_valid = 1'b0; in_valid = 1'b0;
        kx_done = 1'b1;                         // done in the very cycle kx_start is high
        n_checks++; if ({kx_start, key_loaded, dp_load, busy} !== 4'b1001) $display("FAIL key_wins_state: {kx_start,key_loaded,dp_load,busy} got %b want 1001", {kx_start, key_loaded, dp_load, busy}); else n_pass++;
        tick;
        kx_done = 1'b0;
        n_checks++; if (key_loaded !== 1'b1 || busy !== 1'b0 || dp_load !== 1'b0) $display("FAIL early_kx_done: key_loaded %b busy %b dp_load %b want 1 0 0", key_loaded, busy, dp_load); else n_pass++;
    endtask

    task automatic test_reset_mid_round;
        logic [8:0] v;
        int bad = 0;
        in_valid = 1'b1; in_data = PT;
        tick;                                   // LOAD
        in_valid = 1'b0;
        repeat (5) tick;                        // 5th ROUND cycle
        n_checks++; if (rk_sel !== 4'd5 || dp_en !== 1'b1) $display("FAIL round5: rk_sel %0d dp_en %b want 5 1", rk_sel, dp_en); else n_pass++;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        v = {key_ready, in_ready, kx_start, key_loaded, dp_load, dp_en, dp_final, out_valid, busy};
        n_checks++; if (v !== 9'b1_0000_0000 || rk_sel !== 4'd0) $display("FAIL abort_ctrl: ctrl %b rk_sel %0d want 100000000 0", v, rk_sel); else n_pass++;
        n_checks++; if (dp_data !== '0 || out_data !== '0) $display("FAIL abort_data: dp_data %h out_data %h want 0", dp_data, out_data); else n_pass++;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (in_ready !== 1'b0 || dp_load !== 1'b0) bad++;
            tick;
        end
        n_checks++; if (bad != 0) $display("FAIL refuse_after_abort: %0d accepting cycles, want 0", bad); else n_pass++;
        // Reload the key; the waiting block is then accepted and encrypts cleanly.
        key_valid = 1'b1;
        tick;
        key_valid = 1'b0; kx_done = 1'b1;
        tick;
        kx_done = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || key_loaded !== 1'b1) $display("FAIL accept_after_rekey: in_ready %b key_loaded %b want 1 1", in_ready, key_loaded); else n_pass++;
        tick;                                   // LOAD
        in_valid = 1'b0;
        repeat (11) tick;                       // 10 ROUND cycles then OUT
        n_checks++; if (out_valid !== 1'b1 || out_data !== CT) $display("FAIL reencrypt: out_valid %b data %h want 1 %h", out_valid, out_data, CT); else n_pass++;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL reencrypt_drain: busy %b out_valid %b want 0 0", busy, out_valid); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; key_valid = 0; kx_done = 0; in_valid = 0; in_data = '0; out_ready = 0;
        expand_key(KEY);
        test_reset;
        test_no_key_stall;
        test_key_load;
        test_encrypt;
        test_out_stall;
        test_key_priority;
        test_reset_mid_round;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
